nmp_axi4l_engine: RTL and testbench
===================================

# nmp_axi4l_engine

Parametrised near-memory processing engine behind an AXI4-Lite slave port, next generation of the matrix-add `nmp_wrapper`. It holds three local banks: operands A and B, and result C. The host fills A and B over AXI4-Lite, programs an element count and operation, starts the engine, polls for done, and reads the element-wise results back from C. Each bank has DEPTH 32-bit words, and each bank is independently addressed.

## Interface
- `DEPTH`, 256: words per bank. Must be a power of two, ≤ 2^(AXI_ADDR_W-4).
- `AXI_ADDR_W`, 12: AXI byte-address width.
- `ACLK` in, 1: the single clock.
- `ARESETN` in, 1: reset, asynchronous and active-low.
- `S_AXI_AWADDR` in, AXI_ADDR_W: write address (byte).
- `S_AXI_AWVALID` in, 1 / `S_AXI_AWREADY` out, 1: write-address handshake.
- `S_AXI_WDATA` in, 32: write data.
- `S_AXI_WSTRB` in, 4: byte strobes. Honoured on bank writes; ignored for registers.
- `S_AXI_WVALID` in, 1 / `S_AXI_WREADY` out, 1: write-data handshake.
- `S_AXI_BRESP` out, 2 / `S_AXI_BVALID` out, 1 / `S_AXI_BREADY` in, 1: write response.
- `S_AXI_ARADDR` in, AXI_ADDR_W: read address (byte).
- `S_AXI_ARVALID` in, 1 / `S_AXI_ARREADY` out, 1: read-address handshake.
- `S_AXI_RDATA` out, 32 / `S_AXI_RRESP` out, 2 / `S_AXI_RVALID` out, 1 / `S_AXI_RREADY` in, 1: read data.
- `irq` out, 1: level interrupt. Equals DONE & IRQ_EN.

## Operation
- Region select is addr[AXI_ADDR_W-1:AXI_ADDR_W-2]: 00 registers, 01 bank A, 10 bank B, 11 bank C (read-only).
- Word index is addr[AXI_ADDR_W-3:2]. Address bits [1:0] are ignored.
- Registers:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bits[2:1] OP, bit3 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY, bit1 DONE (sticky; write 1 to clear).
  - 0x08 LEN: element count, bits[log2(DEPTH):0].
  - Other register offsets read 0 and ignore writes, with OKAY.
- OP encoding:
  - 00: C = A+B.
  - 01: C = A−B.
  - 10: C = low 32 bits of A×B (unsigned).
  - 11: C = unsigned max(A,B).
  - Add and sub wrap modulo 2^32.
- Engine FSM:
  - IDLE → RUN on a START write while not BUSY, provided 0 < LEN ≤ DEPTH. START also clears DONE.
  - START with LEN = 0 or LEN > DEPTH: no RUN; DONE is set on the next cycle.
  - RUN: issue index i = 0..LEN−1 to A/B, one per cycle. Synchronous-read data returns one cycle later and C[i] is written that cycle.
  - RUN → DRAIN after the last issue. DRAIN → IDLE after the last C write, setting DONE.
- Errors (SLVERR):
  - Write to C. Data is dropped.
  - Bank access with word index ≥ DEPTH. Writes are dropped; reads return 0.
  - Bank read or write while BUSY. Writes are dropped; reads return 0.
  - START while BUSY. Ignored; the engine is unaffected.
- Register accesses are always OKAY.

## Timing
- Reset values:
  - All READY/VALID outputs 0; BRESP/RRESP 00; RDATA 0; irq 0.
  - CTRL, LEN, STATUS 0; FSM in IDLE.
  - Bank contents are not reset.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID = 1.
  - AW without W (or W without AW) waits; no partial acceptance.
- Read channel:
  - ARREADY pulses one cycle when ARVALID & !RVALID & no read in flight.
  - RVALID rises 2 cycles after the handshake (address register + BRAM read) for every region.
  - RDATA/RRESP are held stable until RREADY.
- Engine latency: START handshake at cycle T → BUSY = 1 at T+1 → DONE = 1 and BUSY = 0 at T+LEN+3. irq follows DONE in the same cycle.
- Ordering: a STATUS read accepted in the cycle DONE sets returns the pre-set value.
- Simultaneous DONE-clear write and DONE-set event: the set wins.
- ARESETN low mid-RUN: FSM to IDLE at once; C is partially written; DONE stays 0.
- In-flight AXI transactions are abandoned by reset. The master must also reset.

## Test plan
- Reset: drive ARESETN = 0 mid-clock → all outputs 0 immediately; STATUS reads 0 after release.
- Add 4×4:
  - Write A[k] = k and B[k] = 2k for k = 0..15; LEN = 16; OP = 00; START.
  - DONE at START+19; C[k] reads 3k, all OKAY.
- Ops at DEPTH:
  - LEN = 256, A[k] = 0xFFFFFFF0+k, B[k] = 0x20.
  - OP 00 → C[0] = 0x10 (wrap). OP 01 → C[0] = 0xFFFFFFD0. OP 10 → C[1] = 0xFFFFFE20. OP 11 → C[0] = 0xFFFFFFF0.
- Protection while BUSY:
  - Write A[0], read C[0], and write START during RUN → each returns SLVERR (SLVERR on the read); A[0] unchanged.
  - Writing C at any time → SLVERR.
- Boundaries:
  - LEN = 0 → DONE next cycle, C untouched.
  - LEN = 257 → same as LEN = 0.
  - WSTRB = 4'b0011 on A[5] preserves the upper 16 bits.
  - Backpressure with BREADY/RREADY held low for 5 cycles → responses held stable.
- Interrupt: IRQ_EN = 1 → irq rises with DONE; writing STATUS = 0x2 drops irq the next cycle.

Source files
------------

// File: rtl/nmp_axi4l_engine_if.sv
// AXI4-Lite slave bundle for the near-memory processing engine.
interface nmp_axi4l_engine_if #(
    parameter int unsigned AXI_ADDR_W = 12
);
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/nmp_axi4l_engine.sv
// Near-memory element-wise engine: banks A/B/C behind an AXI4-Lite slave,
// computing C[i] = op(A[i], B[i]) for i < LEN.
module nmp_axi4l_engine #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AXI_ADDR_W = 12
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    nmp_axi4l_engine_if.slave s_axi,
    output logic              irq
);
    localparam int unsigned IdxW  = $clog2(DEPTH);
    localparam int unsigned LenW  = IdxW + 1;
    localparam int unsigned WIdxW = AXI_ADDR_W - 4;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LenW-1:0]  cnt_q, cnt_d;
    logic [LenW-1:0]  len_q, run_len_q;
    logic [1:0]       op_q, run_op_q;
    logic             irq_en_q, done_q;
    logic             res_valid_q;
    logic [IdxW-1:0]  res_idx_q;
    logic [31:0]      eng_a_q, eng_b_q, result;
    logic             start_run, finish, busy, len_ok;

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic [31:0] mem_c [DEPTH];

    logic             awready_q, bvalid_q;
    logic [1:0]       bresp_q;
    logic             arready_q, rd_pend_q, rvalid_q, rd_err_q;
    logic [1:0]       rresp_q, rd_region_q;
    logic [IdxW-1:0]  rd_idx_q;
    logic [31:0]      rd_reg_q, rdata_q, reg_rdata;

    // Write-side decode
    logic             wr_hs, wr_oob, wr_start, start_ok, wr_err;
    logic             we_ctrl, we_len, clr_done, we_a, we_b;
    logic [1:0]       wr_region;
    logic [WIdxW-1:0] wr_widx;
    logic [IdxW-1:0]  wr_idx;

    assign busy      = (state_q != StIdle);
    assign len_ok    = (len_q != '0) && (32'(len_q) <= DEPTH);
    assign wr_hs     = awready_q & s_axi.awvalid & s_axi.wvalid;
    assign wr_region = s_axi.awaddr[AXI_ADDR_W-1 -: 2];
    assign wr_widx   = s_axi.awaddr[AXI_ADDR_W-3:2];
    assign wr_idx    = wr_widx[IdxW-1:0];
    assign wr_oob    = 32'(wr_widx) >= DEPTH;
    assign wr_start  = wr_hs && (wr_region == 2'b00) && (wr_widx == '0) && s_axi.wdata[0];
    assign start_ok  = wr_start & ~busy;
    assign we_ctrl   = wr_hs && (wr_region == 2'b00) && (wr_widx == '0) && !(wr_start && busy);
    assign clr_done  = wr_hs && (wr_region == 2'b00) && (wr_widx == WIdxW'(1)) && s_axi.wdata[1];
    assign we_len    = wr_hs && (wr_region == 2'b00) && (wr_widx == WIdxW'(2));
    assign we_a      = wr_hs && (wr_region == 2'b01) && !wr_oob && !busy;
    assign we_b      = wr_hs && (wr_region == 2'b10) && !wr_oob && !busy;
    assign wr_err    = (wr_region == 2'b11) || (wr_start && busy) ||
                       (wr_region[0] ^ wr_region[1]) && (wr_oob || busy);

    // Read-side decode
    logic             ar_hs, ar_oob;
    logic [1:0]       ar_region;
    logic [WIdxW-1:0] ar_widx;

    assign ar_hs     = arready_q & s_axi.arvalid;
    assign ar_region = s_axi.araddr[AXI_ADDR_W-1 -: 2];
    assign ar_widx   = s_axi.araddr[AXI_ADDR_W-3:2];
    assign ar_oob    = 32'(ar_widx) >= DEPTH;

    always_comb begin
        reg_rdata = '0;
        if (ar_widx == '0) begin
            reg_rdata = {28'd0, irq_en_q, op_q, 1'b0};
        end else if (ar_widx == WIdxW'(1)) begin
            reg_rdata = {30'd0, done_q, busy};
        end else if (ar_widx == WIdxW'(2)) begin
            reg_rdata = 32'(len_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_run = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok && len_ok) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    start_run = 1'b1;
                end
            end
            StRun: begin
                cnt_d = cnt_q + LenW'(1);
                if (cnt_q == run_len_q - LenW'(1)) state_d = StDrain;
            end
            StDrain: begin
                // Leave only once the final C write has retired
                if (!res_valid_q) begin
                    state_d = StIdle;
                    finish  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (run_op_q)
            2'b00:   result = eng_a_q + eng_b_q;
            2'b01:   result = eng_a_q - eng_b_q;
            2'b10:   result = eng_a_q * eng_b_q;
            default: result = (eng_a_q > eng_b_q) ? eng_a_q : eng_b_q;
        endcase
    end

    // Bank storage is deliberately left out of reset
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we_a && s_axi.wstrb[i]) mem_a[wr_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            if (we_b && s_axi.wstrb[i]) mem_b[wr_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
        end
        eng_a_q <= mem_a[cnt_q[IdxW-1:0]];
        eng_b_q <= mem_b[cnt_q[IdxW-1:0]];
        if (res_valid_q) mem_c[res_idx_q] <= result;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            run_len_q   <= '0;
            op_q        <= '0;
            run_op_q    <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            arready_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_region_q <= '0;
            rd_idx_q    <= '0;
            rd_reg_q    <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= RespOkay;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= (state_q == StRun);
            res_idx_q   <= cnt_q[IdxW-1:0];

            awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
            if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RespSlvErr : RespOkay;
            end

            if (we_ctrl) begin
                op_q     <= s_axi.wdata[2:1];
                irq_en_q <= s_axi.wdata[3];
            end
            if (we_len) len_q <= s_axi.wdata[LenW-1:0];
            if (start_run) begin
                run_op_q  <= s_axi.wdata[2:1];
                run_len_q <= len_q;
            end
            // Later assignments take priority: a finishing run beats a clear
            if (clr_done) done_q <= 1'b0;
            if (start_ok) done_q <= ~len_ok;
            if (finish)   done_q <= 1'b1;

            arready_q <= s_axi.arvalid & ~rvalid_q & ~rd_pend_q & ~arready_q;
            rd_pend_q <= ar_hs;
            if (ar_hs) begin
                rd_region_q <= ar_region;
                rd_idx_q    <= ar_widx[IdxW-1:0];
                rd_err_q    <= (ar_region != 2'b00) && (ar_oob || busy);
                rd_reg_q    <= reg_rdata;
            end
            if (rvalid_q && s_axi.rready) rvalid_q <= 1'b0;
            if (rd_pend_q) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_err_q ? RespSlvErr : RespOkay;
                if (rd_err_q) begin
                    rdata_q <= '0;
                end else begin
                    case (rd_region_q)
                        2'b00:   rdata_q <= rd_reg_q;
                        2'b01:   rdata_q <= mem_a[rd_idx_q];
                        2'b10:   rdata_q <= mem_b[rd_idx_q];
                        default: rdata_q <= mem_c[rd_idx_q];
                    endcase
                end
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign irq           = done_q & irq_en_q;
endmodule

// File: tb/tb_nmp_axi4l_engine.sv
// Self-checking bench for nmp_axi4l_engine: vector table, directed corner cases
// and randomized jobs against a reference model of the three banks.
module tb_nmp_axi4l_engine;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 12;
    localparam logic [AW-1:0] RegCtrl   = 12'h000;
    localparam logic [AW-1:0] RegStatus = 12'h004;
    localparam logic [AW-1:0] RegLen    = 12'h008;
    localparam logic [AW-1:0] BaseA     = 12'h400;
    localparam logic [AW-1:0] BaseB     = 12'h800;
    localparam logic [AW-1:0] BaseC     = 12'hC00;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    logic irq;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;
    logic irq_hs, irq_after;

    logic [31:0] a_m [DEPTH];
    logic [31:0] b_m [DEPTH];
    logic [31:0] c_m [DEPTH];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    nmp_axi4l_engine_if #(.AXI_ADDR_W(AW)) bus ();

    nmp_axi4l_engine #(.DEPTH(DEPTH), .AXI_ADDR_W(AW)) dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .s_axi  (bus),
        .irq    (irq)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            default: return (a > b) ? a : b;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int k);
        return base + AW'(k * 4);
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold, output logic [1:0] resp);
        int n;
        logic stable;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!bus.awready && n < 100);
        if (!bus.awready) begin
            timeout("aw_handshake");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            resp = 2'bxx;
            return;
        end
        hs_cyc = cyc;
        irq_hs = irq;
        @(posedge ACLK);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        irq_after   = irq;
        n = 0;
        while (!bus.bvalid && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (!bus.bvalid) begin
            timeout("b_valid");
            resp = 2'bxx;
            return;
        end
        resp   = bus.bresp;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            if (!bus.bvalid || bus.bresp !== resp) stable = 1'b0;
        end
        if (hold > 0) check("b_held_stable", 32'(stable), 32'd1);
        bus.bready = 1'b1;
        @(posedge ACLK);
        #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int hold, output logic [31:0] data,
                            output logic [1:0] resp);
        int n, h;
        logic stable;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!bus.arready && n < 100);
        if (!bus.arready) begin
            timeout("ar_handshake");
            bus.arvalid = 1'b0;
            data = 'x;
            resp = 2'bxx;
            return;
        end
        h = cyc;
        @(posedge ACLK);
        #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (!bus.rvalid) begin
            timeout("r_valid");
            data = 'x;
            resp = 2'bxx;
            return;
        end
        check("r_latency", 32'(cyc - h), 32'd2);
        data   = bus.rdata;
        resp   = bus.rresp;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp) stable = 1'b0;
        end
        if (hold > 0) check("r_held_stable", 32'(stable), 32'd1);
        bus.rready = 1'b1;
        @(posedge ACLK);
        #1;
        bus.rready = 1'b0;
    endtask

    task automatic wr_ok(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, 0, r);
        check($sformatf("bresp@%03h", addr), 32'(r), 32'd0);
    endtask

    task automatic bank_write(input logic is_b, input int k, input logic [31:0] data,
                              input logic [3:0] strb);
        logic [1:0] r;
        axi_write(addr_of(is_b ? BaseB : BaseA, k), data, strb, 0, r);
        check("bank_bresp", 32'(r), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                if (is_b) b_m[k][8*i +: 8] = data[8*i +: 8];
                else      a_m[k][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    // Program LEN and issue START; the model applies the job up front.
    task automatic start_job(input logic [1:0] op, input int len, input logic irq_en);
        wr_ok(RegLen, 32'(len));
        wr_ok(RegCtrl, {28'd0, irq_en, op, 1'b1});
        if (len > 0 && len <= int'(DEPTH)) begin
            for (int k = 0; k < len; k++) c_m[k] = ref_op(op, a_m[k], b_m[k]);
        end
    endtask

    task automatic wait_done();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 400; i++) begin
            axi_read(RegStatus, 0, d, r);
            if (d[1]) return;
        end
        timeout("done_wait");
    endtask

    task automatic check_c(input int len);
        logic [31:0] d;
        logic [1:0]  r;
        for (int k = 0; k < len; k++) begin
            axi_read(addr_of(BaseC, k), 0, d, r);
            check($sformatf("C[%0d]", k), d, c_m[k]);
            check($sformatf("C[%0d]_rresp", k), 32'(r), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  op;
        int          n, len, t0;

        vecs[0] = '{op: 2'd0, a: 32'd1,          b: 32'd2,          exp: 32'd3};
        vecs[1] = '{op: 2'd0, a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'd0};
        vecs[2] = '{op: 2'd1, a: 32'd0,          b: 32'd1,          exp: 32'hFFFF_FFFF};
        vecs[3] = '{op: 2'd1, a: 32'd100,        b: 32'd58,         exp: 32'd42};
        vecs[4] = '{op: 2'd2, a: 32'd3,          b: 32'd5,          exp: 32'd15};
        vecs[5] = '{op: 2'd2, a: 32'h0001_0000,  b: 32'h0001_0000,  exp: 32'd0};
        vecs[6] = '{op: 2'd2, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'd1};
        vecs[7] = '{op: 2'd3, a: 32'd5,          b: 32'd7,          exp: 32'd7};
        vecs[8] = '{op: 2'd3, a: 32'h8000_0000,  b: 32'h7FFF_FFFF,  exp: 32'h8000_0000};
        vecs[9] = '{op: 2'd3, a: 32'd9,          b: 32'd9,          exp: 32'd9};

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);

        // Register reset values
        check("irq_reset", 32'(irq), 32'd0);
        axi_read(RegStatus, 0, d, r);
        check("status_reset", d, 32'd0);
        axi_read(RegCtrl, 0, d, r);
        check("ctrl_reset", d, 32'd0);
        axi_read(RegLen, 0, d, r);
        check("len_reset", d, 32'd0);
        axi_read(12'h00C, 0, d, r);
        check("reg_unmapped", d, 32'd0);
        check("reg_unmapped_rresp", 32'(r), 32'd0);

        // Byte strobes on A[5]
        bank_write(1'b0, 5, 32'hAAAA_AAAA, 4'hF);
        bank_write(1'b0, 5, 32'h1234_5678, 4'b0011);
        axi_read(addr_of(BaseA, 5), 0, d, r);
        check("A5_strobe", d, a_m[5]);
        check("A5_strobe_const", d, 32'hAAAA_5678);

        // Add 16 elements with latency measured on irq
        for (int k = 0; k < 16; k++) begin
            bank_write(1'b0, k, 32'(k), 4'hF);
            bank_write(1'b1, k, 32'(2 * k), 4'hF);
        end
        wr_ok(RegLen, 32'd16);
        wr_ok(RegCtrl, 32'h9);
        t0 = hs_cyc;
        for (int k = 0; k < 16; k++) c_m[k] = 32'(3 * k);
        n = 0;
        while (!irq && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        if (!irq) timeout("irq_wait");
        else check("done_latency", 32'(cyc - t0), 32'd19);
        axi_read(RegStatus, 0, d, r);
        check("status_done", d, 32'h2);
        check_c(16);
        wr_ok(RegStatus, 32'h2);
        check("irq_at_clear", 32'(irq_hs), 32'd1);
        check("irq_after_clear", 32'(irq_after), 32'd0);
        wr_ok(RegCtrl, 32'h0);

        // Vector table, one element per job
        foreach (vecs[i]) begin
            bank_write(1'b0, 0, vecs[i].a, 4'hF);
            bank_write(1'b1, 0, vecs[i].b, 4'hF);
            start_job(vecs[i].op, 1, 1'b0);
            wait_done();
            axi_read(BaseC, 0, d, r);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Full-depth runs of every op
        for (int k = 0; k < int'(DEPTH); k++) begin
            bank_write(1'b0, k, 32'hFFFF_FFF0 + 32'(k), 4'hF);
            bank_write(1'b1, k, 32'h20, 4'hF);
        end
        for (int o = 0; o < 4; o++) begin
            op = 2'(o);
            start_job(op, int'(DEPTH), 1'b0);
            if (o == 0) begin
                axi_read(RegStatus, 0, d, r);
                check("status_busy", d, 32'h1);
                axi_write(BaseA, 32'hDEAD_BEEF, 4'hF, 0, r);
                check("busy_wr_A", 32'(r), 32'd2);
                axi_read(BaseC, 0, d, r);
                check("busy_rd_C_resp", 32'(r), 32'd2);
                check("busy_rd_C_data", d, 32'd0);
                axi_write(RegCtrl, 32'h1, 4'hF, 0, r);
                check("busy_start", 32'(r), 32'd2);
            end
            wait_done();
            check_c(int'(DEPTH));
            axi_read(BaseC, 0, d, r);
            case (o)
                0: check("op0_C0", d, 32'h0000_0010);
                1: check("op1_C0", d, 32'hFFFF_FFD0);
                2: begin
                    axi_read(addr_of(BaseC, 1), 0, d, r);
                    check("op2_C1", d, 32'hFFFF_FE20);
                end
                default: check("op3_C0", d, 32'hFFFF_FFF0);
            endcase
        end
        axi_read(BaseA, 0, d, r);
        check("A0_unchanged", d, 32'hFFFF_FFF0);

        // C is read-only
        axi_write(addr_of(BaseC, 2), 32'h5555_5555, 4'hF, 0, r);
        check("wr_C_resp", 32'(r), 32'd2);
        axi_read(addr_of(BaseC, 2), 0, d, r);
        check("wr_C_dropped", d, c_m[2]);

        // Degenerate lengths complete immediately without touching C
        for (int t = 0; t < 2; t++) begin
            wr_ok(RegStatus, 32'h2);
            axi_read(RegStatus, 0, d, r);
            check("status_cleared", d, 32'd0);
            start_job(2'd0, (t == 0) ? 0 : int'(DEPTH) + 1, 1'b0);
            axi_read(RegStatus, 0, d, r);
            check($sformatf("badlen%0d_status", t), d, 32'h2);
            axi_read(BaseC, 0, d, r);
            check($sformatf("badlen%0d_C0", t), d, c_m[0]);
        end

        // Randomized jobs against the model
        for (int rnd = 0; rnd < 4; rnd++) begin
            len = $urandom_range(1, 40);
            op  = 2'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                bank_write(1'b0, k, $urandom, 4'hF);
                bank_write(1'b1, k, $urandom, 4'($urandom_range(1, 15)));
            end
            start_job(op, len, 1'b0);
            wait_done();
            check_c(len);
        end

        // Responses held under backpressure
        axi_write(addr_of(BaseB, 3), 32'h0BAD_F00D, 4'hF, 5, r);
        check("bp_bresp", 32'(r), 32'd0);
        b_m[3] = 32'h0BAD_F00D;
        axi_read(addr_of(BaseB, 3), 5, d, r);
        check("bp_rdata", d, b_m[3]);
        axi_write(BaseC, 32'h1, 4'hF, 5, r);
        check("bp_bresp_err", 32'(r), 32'd2);

        // Asynchronous reset in the middle of a run
        start_job(2'd0, int'(DEPTH), 1'b1);
        repeat (20) @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        check("rst_ctl_outputs",
              32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, irq}), 32'd0);
        check("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        axi_read(RegStatus, 0, d, r);
        check("rst_status", d, 32'd0);
        axi_read(RegCtrl, 0, d, r);
        check("rst_ctrl", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
